// File: rtl/serial_block_subtractor_if.sv
// Handshake and operand/result bundle for serial_block_subtractor.
//   Start    : request from the ALU controller (master -> slave)
//   A, B     : minuend and subtrahend (master -> slave)
//   Busy     : slices are being processed (slave -> master)
//   Done     : one-cycle completion pulse (slave -> master)
//   Diff     : A - B modulo 2^WIDTH (slave -> master)
//   Bout     : borrow, 1 iff unsigned A < B (slave -> master)
//   Overflow : signed overflow of A - B (slave -> master)
interface serial_block_subtractor_if #(
  parameter int WIDTH = 32
) ();
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Overflow;

  modport master (
    output Start, A, B,
    input  Busy, Done, Diff, Bout, Overflow
  );

  modport slave (
    input  Start, A, B,
    output Busy, Done, Diff, Bout, Overflow
  );
endinterface

// File: rtl/serial_block_subtractor.sv
// Multi-cycle subtractor: Diff = A + ~B + 1, one BLOCK-bit slice per clock,
// with the slice carry rippled through a register. Reports borrow and signed
// overflow together with the difference at the completion edge.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset (aborts any operation in flight)
//   bus : serial_block_subtractor_if.slave (Start/A/B in, Busy/Done/Diff/
//         Bout/Overflow out, all outputs registered)
module serial_block_subtractor #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_block_subtractor_if.slave  bus
);

  localparam int N  = WIDTH / BLOCK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_nb;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic             carry;
  logic [KW-1:0]    k;
  logic [BLOCK-1:0] a_slice;
  logic [BLOCK-1:0] nb_slice;
  logic [BLOCK:0]   sum;
  logic             last;
  logic             accept;
  logic             busy_nxt;
  logic             done_nxt;

  assign last   = (k == KW'(N - 1));
  // Start is only looked at when no operation is in progress.
  assign accept = ((state == IDLE) || (state == DONE)) && bus.Start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (bus.Start) next_state = RUN;
        else           next_state = IDLE;
      end
      RUN: begin
        if (last) next_state = DONE;
        else      next_state = RUN;
      end
      DONE: begin
        if (bus.Start) next_state = RUN;
        else           next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: values Busy/Done take after the coming edge.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (next_state)
      RUN:     busy_nxt = 1'b1;
      DONE:    done_nxt = 1'b1;
      default: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
      end
    endcase
  end

  // Slice adder for the current k; work_nxt is the working result with this
  // slice merged in, so the last slice can go straight to Diff.
  always_comb begin
    a_slice  = op_a[k*BLOCK +: BLOCK];
    nb_slice = op_nb[k*BLOCK +: BLOCK];
    sum      = {1'b0, a_slice} + {1'b0, nb_slice} + {{BLOCK{1'b0}}, carry};
    work_nxt = work;
    work_nxt[k*BLOCK +: BLOCK] = sum[BLOCK-1:0];
  end

  // Operand latch, slice iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a         <= {WIDTH{1'b0}};
      op_nb        <= {WIDTH{1'b0}};
      work         <= {WIDTH{1'b0}};
      carry        <= 1'b0;
      k            <= {KW{1'b0}};
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
      bus.Diff     <= {WIDTH{1'b0}};
      bus.Bout     <= 1'b0;
      bus.Overflow <= 1'b0;
    end else begin
      bus.Busy <= busy_nxt;
      bus.Done <= done_nxt;
      if (accept) begin
        op_a  <= bus.A;
        op_nb <= ~bus.B;
        work  <= {WIDTH{1'b0}};
        carry <= 1'b1;
        k     <= {KW{1'b0}};
      end else if (state == RUN) begin
        work  <= work_nxt;
        carry <= sum[BLOCK];
        k     <= k + KW'(1);
        if (last) begin
          bus.Diff <= work_nxt;
          bus.Bout <= ~sum[BLOCK];
          // Operand signs differ (op_nb holds ~B, so equal latched MSBs) and
          // the result sign departs from A.
          bus.Overflow <= (op_a[WIDTH-1] == op_nb[WIDTH-1]) &&
                          (work_nxt[WIDTH-1] != op_a[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_block_subtractor.sv
// Self-checking bench for serial_block_subtractor: a scoreboard queue holds
// expected results pushed at issue time and popped on each Done pulse.
module tb_serial_block_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  serial_block_subtractor_if #(.WIDTH(32)) bus ();

  serial_block_subtractor #(.WIDTH(32), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: plain 32-bit subtraction and comparisons.
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.diff = a - b;
    e.bout = (a < b);
    e.ovf  = (a[31] != b[31]) && (e.diff[31] != a[31]);
    sb.push_back(e);
  endtask

  // Drive Start for one edge; returns positioned just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    if (push) push_exp(a, b);
    step();
    bus.Start = 1'b0;
  endtask

  // Bounded wait for Done; counts cycles elapsed and cycles with Busy high.
  task automatic wait_for_done(input int budget, output int cycles,
                               output int busy_cycles, output bit seen);
    cycles      = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (cycles < budget) begin
      if (bus.Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.Busy === 1'b1) busy_cycles++;
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    repeat (3) step();
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    total++; if (bus.Diff !== 32'd0) begin bad++; $display("FAIL reset_diff got=%h exp=0", bus.Diff); end
    total++; if (bus.Bout !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b exp=0", bus.Bout); end
    total++; if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.Overflow); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    bit seen;
    exp_t e;
    issue(32'd100, 32'd90, 1'b1);
    wait_for_done(20, cyc, bcyc, seen);
    total++; if (!seen || cyc != 8) begin bad++; $display("FAIL basic_latency got=%0d seen=%0b exp=8", cyc, seen); end
    total++; if (bcyc != 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=8", bcyc); end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (bus.Diff !== e.diff) begin bad++; $display("FAIL basic_diff got=%h exp=%h", bus.Diff, e.diff); end
      total++; if (bus.Bout !== e.bout) begin bad++; $display("FAIL basic_bout got=%b exp=%b", bus.Bout, e.bout); end
      total++; if (bus.Overflow !== e.ovf) begin bad++; $display("FAIL basic_ovf got=%b exp=%b", bus.Overflow, e.ovf); end
    end else begin
      total++; bad++; $display("FAIL basic_result got=none exp=done");
    end
    step();
    total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", bus.Done); end
    total++; if (bus.Diff !== 32'd10) begin bad++; $display("FAIL basic_diff_hold got=%h exp=0000000a", bus.Diff); end
  endtask

  task automatic test_overflow();
    logic [31:0] av[2];
    logic [31:0] bv[2];
    int cyc, bcyc;
    bit seen;
    exp_t e;
    av[0] = 32'h7FFFFFFF; bv[0] = 32'hFFFFFFFF;
    av[1] = 32'h80000000; bv[1] = 32'h00000001;
    for (int i = 0; i < 2; i++) begin
      issue(av[i], bv[i], 1'b1);
      wait_for_done(20, cyc, bcyc, seen);
      if (seen && sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (bus.Diff !== e.diff) begin bad++; $display("FAIL ovf%0d_diff got=%h exp=%h", i, bus.Diff, e.diff); end
        total++; if (bus.Bout !== e.bout) begin bad++; $display("FAIL ovf%0d_bout got=%b exp=%b", i, bus.Bout, e.bout); end
        total++; if (bus.Overflow !== e.ovf) begin bad++; $display("FAIL ovf%0d_ovf got=%b exp=%b", i, bus.Overflow, e.ovf); end
      end else begin
        total++; bad++; $display("FAIL ovf%0d_result got=none exp=done", i);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    bit seen;
    exp_t e;
    issue(32'd10, 32'd90, 1'b1);
    wait_for_done(20, cyc, bcyc, seen);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (bus.Diff !== e.diff) begin bad++; $display("FAIL b2b0_diff got=%h exp=%h", bus.Diff, e.diff); end
      total++; if (bus.Bout !== e.bout) begin bad++; $display("FAIL b2b0_bout got=%b exp=%b", bus.Bout, e.bout); end
      total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_in_done got=%b exp=0", bus.Busy); end
    end else begin
      total++; bad++; $display("FAIL b2b0_result got=none exp=done");
    end
    // Start in the Done cycle itself.
    issue(32'd10, 32'hFFFFFFF6, 1'b1);
    total++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b exp=1", bus.Busy); end
    wait_for_done(20, cyc, bcyc, seen);
    total++; if (!seen || cyc != 8) begin bad++; $display("FAIL b2b_latency got=%0d seen=%0b exp=8", cyc, seen); end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (bus.Diff !== e.diff) begin bad++; $display("FAIL b2b1_diff got=%h exp=%h", bus.Diff, e.diff); end
      total++; if (bus.Bout !== e.bout) begin bad++; $display("FAIL b2b1_bout got=%b exp=%b", bus.Bout, e.bout); end
    end else begin
      total++; bad++; $display("FAIL b2b1_result got=none exp=done");
    end
    step();
  endtask

  task automatic test_ignore_start();
    int cyc, bcyc, dones;
    bit seen;
    exp_t e;
    issue(32'd3456, 32'd8347, 1'b1);
    step();
    step();
    bus.A = 32'd1;
    bus.B = 32'd2;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    total++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b exp=1", bus.Busy); end
    wait_for_done(20, cyc, bcyc, seen);
    total++; if (!seen || (cyc + 3) != 8) begin bad++; $display("FAIL ign_latency got=%0d seen=%0b exp=8", cyc + 3, seen); end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (bus.Diff !== e.diff) begin bad++; $display("FAIL ign_diff got=%h exp=%h", bus.Diff, e.diff); end
      total++; if (bus.Bout !== e.bout) begin bad++; $display("FAIL ign_bout got=%b exp=%b", bus.Bout, e.bout); end
      total++; if (bus.Overflow !== e.ovf) begin bad++; $display("FAIL ign_ovf got=%b exp=%b", bus.Overflow, e.ovf); end
    end else begin
      total++; bad++; $display("FAIL ign_result got=none exp=done");
    end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.Done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL ign_extra_done got=%0d exp=0", dones); end
  endtask

  task automatic test_reset_abort();
    int cyc, bcyc, dones;
    bit seen;
    exp_t e;
    issue(32'd1, 32'd2, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.Busy); end
    total++; if (bus.Diff !== 32'd0 || bus.Bout !== 1'b0 || bus.Overflow !== 1'b0 || bus.Done !== 1'b0)
      begin bad++; $display("FAIL abort_outputs got=%h/%b/%b/%b exp=0/0/0/0", bus.Diff, bus.Bout, bus.Overflow, bus.Done); end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.Done === 1'b1) dones++;
      step();
    end
    total++; if (dones != 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", dones); end
    issue(32'd5, 32'd5, 1'b1);
    wait_for_done(20, cyc, bcyc, seen);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (bus.Diff !== e.diff) begin bad++; $display("FAIL abort_next_diff got=%h exp=%h", bus.Diff, e.diff); end
      total++; if (bus.Bout !== e.bout) begin bad++; $display("FAIL abort_next_bout got=%b exp=%b", bus.Bout, e.bout); end
    end else begin
      total++; bad++; $display("FAIL abort_next_result got=none exp=done");
    end
    step();
  endtask

  task automatic test_random();
    int cyc, bcyc;
    bit seen;
    exp_t e;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) b = a;
      if (i == 1) a = 32'd0;
      issue(a, b, 1'b1);
      wait_for_done(20, cyc, bcyc, seen);
      if (seen && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (bus.Diff !== e.diff || bus.Bout !== e.bout || bus.Overflow !== e.ovf) begin
          bad++;
          $display("FAIL rand%0d a=%h b=%h got=%h/%b/%b exp=%h/%b/%b", i, a, b,
                   bus.Diff, bus.Bout, bus.Overflow, e.diff, e.bout, e.ovf);
        end
      end else begin
        total++; bad++; $display("FAIL rand%0d_result got=none exp=done", i);
      end
      // Odd iterations restart in the Done cycle, even ones idle first.
      if (i % 2 == 0) step();
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
